// File: rtl/stochastic_sampler.sv
// -----------------------------------------------------------------------------
// stochastic_sampler
//   Turns a stream of 8-bit unit activation probabilities into Bernoulli
//   neuron states. A unit samples to 1 when the random byte is below its
//   probability. NUM_UNITS samples are packed into one layer word. The word is
//   presented downstream with a valid/ready handshake.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   reset       asynchronous, active-high reset
//   start       one-cycle pulse that begins a new layer
//   prob_valid  prob_data carries a valid probability
//   prob_data   unsigned probability 0..255 (value/256)
//   prob_ready  sampler accepts prob_data this cycle (decoded from state only)
//   rand_in     current byte from the free-running random generator
//   out_valid   out_data/ones_count hold a complete layer
//   out_ready   downstream accepts the layer word
//   out_data    sampled states, bit i = unit i
//   ones_count  number of 1 bits in out_data
//   unit_idx    index of the next unit to be sampled
//   busy        high while collecting or presenting a layer
// -----------------------------------------------------------------------------
module stochastic_sampler #(
  parameter int NUM_UNITS = 16,
  parameter int IDX_W     = 4,
  parameter int CNT_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 prob_valid,
  input  logic [7:0]           prob_data,
  output logic                 prob_ready,
  input  logic [7:0]           rand_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_UNITS-1:0] out_data,
  output logic [CNT_W-1:0]     ones_count,
  output logic [IDX_W-1:0]     unit_idx,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t               state_r;
  state_t               next_state_s;
  logic                 clear_s;
  logic                 accept_s;
  logic                 sample_bit_s;
  logic                 last_unit_s;
  logic                 prob_ready_r;
  logic                 out_valid_r;
  logic                 busy_r;
  logic [NUM_UNITS-1:0] out_data_r;
  logic [CNT_W-1:0]     ones_count_r;
  logic [IDX_W-1:0]     unit_idx_r;

  // prob_ready_r mirrors state_r == COLLECT, so an accept never depends
  // combinationally on prob_valid feeding back into prob_ready.
  assign accept_s     = prob_valid & prob_ready_r;
  assign sample_bit_s = (rand_in < prob_data);
  assign last_unit_s  = (unit_idx_r == IDX_W'(NUM_UNITS - 1));

  // Next-state decode; clear_s marks every entry into COLLECT.
  always_comb begin
    next_state_s = state_r;
    clear_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = COLLECT;
          clear_s      = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      COLLECT: begin
        if (accept_s && last_unit_s) begin
          next_state_s = PRESENT;
        end else begin
          next_state_s = COLLECT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          if (start) begin
            next_state_s = COLLECT;
            clear_s      = 1'b1;
          end else begin
            next_state_s = IDLE;
          end
        end else begin
          next_state_s = PRESENT;
        end
      end
      default: begin
        next_state_s = IDLE;
        clear_s      = 1'b0;
      end
    endcase
  end

  // State register plus registered handshake/status flags decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      prob_ready_r <= 1'b0;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      prob_ready_r <= (next_state_s == COLLECT);
      out_valid_r  <= (next_state_s == PRESENT);
      busy_r       <= (next_state_s != IDLE);
    end
  end

  // Sample datapath: clear on layer start, otherwise record one bit per accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_r   <= {NUM_UNITS{1'b0}};
      ones_count_r <= {CNT_W{1'b0}};
      unit_idx_r   <= {IDX_W{1'b0}};
    end else if (clear_s) begin
      out_data_r   <= {NUM_UNITS{1'b0}};
      ones_count_r <= {CNT_W{1'b0}};
      unit_idx_r   <= {IDX_W{1'b0}};
    end else if (accept_s) begin
      out_data_r[unit_idx_r] <= sample_bit_s;
      ones_count_r           <= ones_count_r + CNT_W'(sample_bit_s);
      // Explicit wrap keeps non-power-of-two NUM_UNITS correct.
      if (last_unit_s) begin
        unit_idx_r <= {IDX_W{1'b0}};
      end else begin
        unit_idx_r <= unit_idx_r + IDX_W'(1);
      end
    end else begin
      out_data_r   <= out_data_r;
      ones_count_r <= ones_count_r;
      unit_idx_r   <= unit_idx_r;
    end
  end

  assign prob_ready = prob_ready_r;
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;
  assign out_data   = out_data_r;
  assign ones_count = ones_count_r;
  assign unit_idx   = unit_idx_r;

endmodule

// File: tb/tb_stochastic_sampler.sv
// -----------------------------------------------------------------------------
// tb_stochastic_sampler
//   Directed, table-driven bench for stochastic_sampler. Table rows give the
//   probability and a random-byte ramp for one whole layer, with the
//   hand-computed word and population count. Hand-written sequences cover the
//   PRESENT hold, the out_ready+start restart, reset mid-layer and a long run
//   against an 8-bit LFSR modelled in the bench.
// -----------------------------------------------------------------------------
module tb_stochastic_sampler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        prob_valid;
  logic [7:0]  prob_data;
  logic        prob_ready;
  logic [7:0]  rand_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [4:0]  ones_count;
  logic [3:0]  unit_idx;
  logic        busy;

  logic [7:0]  rand_drv;
  logic        use_lfsr;
  logic        lfsr_load;
  logic [7:0]  lfsr_r;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Free-running generator: x^8+x^6+x^5+x^4+1, loads the seed while lfsr_load is high.
  always @(posedge clk) begin
    if (lfsr_load) lfsr_r <= 8'h5A;
    else           lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
  end

  assign rand_in = use_lfsr ? lfsr_r : rand_drv;

  stochastic_sampler #(.NUM_UNITS(16), .IDX_W(4), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start),
    .prob_valid(prob_valid), .prob_data(prob_data), .prob_ready(prob_ready),
    .rand_in(rand_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .ones_count(ones_count), .unit_idx(unit_idx),
    .busy(busy)
  );

  typedef struct {
    logic [7:0]  prob;
    logic [7:0]  rbase;
    logic [7:0]  rstep;
    logic        gaps;
    logic [15:0] exp_data;
    logic [4:0]  exp_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_prob_ready"}, 32'(prob_ready), 32'd0);
    chk({nm, "_out_valid"},  32'(out_valid),  32'd0);
    chk({nm, "_busy"},       32'(busy),       32'd0);
    chk({nm, "_out_data"},   32'(out_data),   32'd0);
    chk({nm, "_ones_count"}, 32'(ones_count), 32'd0);
    chk({nm, "_unit_idx"},   32'(unit_idx),   32'd0);
  endtask

  // One full layer: start pulse, 16 accepts (optionally with a gap before each).
  // Returns the bench's own model of the resulting word and count.
  task automatic run_layer(input logic [7:0] prob, input logic [7:0] base,
                           input logic [7:0] stp, input logic gaps,
                           output logic [15:0] mdata, output int mcnt);
    logic [7:0] r;
    mdata = 16'h0000;
    mcnt  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("collect_ready", 32'(prob_ready), 32'd1);
    chk("collect_busy",  32'(busy),       32'd1);
    chk("collect_idx0",  32'(unit_idx),   32'd0);
    chk("collect_clear", 32'(out_data),   32'd0);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        prob_valid = 1'b0;
        prob_data  = prob;
        tick();
        chk("gap_hold_idx", 32'(unit_idx), 32'(i));
      end
      r = base + 8'(int'(stp) * i);
      if (use_lfsr) r = lfsr_r;
      rand_drv   = r;
      prob_valid = 1'b1;
      prob_data  = prob;
      if (r < prob) begin
        mdata[i] = 1'b1;
        mcnt++;
      end
      tick();
      if (i < 15) chk("no_early_valid", 32'(out_valid), 32'd0);
    end
    prob_valid = 1'b0;
    chk("valid_after_last", 32'(out_valid),  32'd1);
    chk("present_ready0",   32'(prob_ready), 32'd0);
    chk("idx_wrap",         32'(unit_idx),   32'd0);
  endtask

  task automatic release_word();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_valid0", 32'(out_valid), 32'd0);
    chk("release_idle",   32'(busy),      32'd0);
  endtask

  initial begin
    logic [15:0] md;
    int          mc;
    int          total;

    // prob, rand base, rand step, gaps, expected word, expected count
    vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0, 16'h0000, 5'd0};
    vecs[1] = '{8'h80, 8'h00, 8'h10, 1'b0, 16'h00FF, 5'd8};
    vecs[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 16'h0000, 5'd0};
    vecs[3] = '{8'hFF, 8'hFE, 8'h00, 1'b1, 16'hFFFF, 5'd16};
    vecs[4] = '{8'h01, 8'h00, 8'h01, 1'b0, 16'h0001, 5'd1};
    vecs[5] = '{8'h10, 8'hF0, 8'h08, 1'b1, 16'h000C, 5'd2};

    reset      = 1'b1;
    start      = 1'b0;
    prob_valid = 1'b0;
    prob_data  = 8'h00;
    out_ready  = 1'b0;
    rand_drv   = 8'h00;
    use_lfsr   = 1'b0;
    lfsr_load  = 1'b1;
    tick();
    tick();
    chk_all_zero("in_reset");
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all_zero("idle");
    end

    // Table-driven layers
    for (int v = 0; v < 6; v++) begin
      run_layer(vecs[v].prob, vecs[v].rbase, vecs[v].rstep, vecs[v].gaps, md, mc);
      chk("vec_out_data",   32'(out_data),   32'(vecs[v].exp_data));
      chk("vec_ones_count", 32'(ones_count), 32'(vecs[v].exp_cnt));
      release_word();
    end

    // PRESENT hold with start ignored, then out_ready+start restarts collection
    run_layer(8'hFF, 8'h10, 8'h00, 1'b1, md, mc);
    chk("hold_data0", 32'(out_data),   32'hFFFF);
    chk("hold_cnt0",  32'(ones_count), 32'd16);
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", 32'(out_valid),  32'd1);
      chk("hold_data",  32'(out_data),   32'hFFFF);
      chk("hold_cnt",   32'(ones_count), 32'd16);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk("restart_busy",  32'(busy),       32'd1);
    chk("restart_ready", 32'(prob_ready), 32'd1);
    chk("restart_valid", 32'(out_valid),  32'd0);
    chk("restart_idx",   32'(unit_idx),   32'd0);
    chk("restart_data",  32'(out_data),   32'd0);
    chk("restart_cnt",   32'(ones_count), 32'd0);

    // 7 accepts of prob 0xFF, start ignored while collecting, then reset mid-layer
    start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      rand_drv   = 8'h20;
      prob_data  = 8'hFF;
      prob_valid = 1'b1;
      tick();
    end
    start      = 1'b0;
    prob_valid = 1'b0;
    chk("partial_idx",  32'(unit_idx),   32'd7);
    chk("partial_data", 32'(out_data),   32'h007F);
    chk("partial_cnt",  32'(ones_count), 32'd7);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    tick();
    reset = 1'b0;
    tick();
    chk_all_zero("post_reset_idle");
    run_layer(vecs[1].prob, vecs[1].rbase, vecs[1].rstep, 1'b0, md, mc);
    chk("post_reset_data", 32'(out_data),   32'h00FF);
    chk("post_reset_cnt",  32'(ones_count), 32'd8);
    release_word();

    // Real generator, seed 0x5A, prob 0x40 over 64 layers
    lfsr_load = 1'b0;
    use_lfsr  = 1'b1;
    total     = 0;
    for (int l = 0; l < 64; l++) begin
      run_layer(8'h40, 8'h00, 8'h00, 1'b0, md, mc);
      chk("lfsr_out_data",   32'(out_data),   32'(md));
      chk("lfsr_ones_count", 32'(ones_count), 32'(mc));
      total += int'(ones_count);
      release_word();
    end
    chk("lfsr_mean_in_3_to_5", 32'((total >= 192) && (total <= 320)), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
